aes_cipher_iter: RTL

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

---
 rtl/aes_cipher_iter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128 encryption, one round per clock.
// The plaintext is accepted in IDLE, with round key 0 applied on the accept
// edge. Rounds 1..10 then run on the following ten edges, so out_valid rises
// on the 11th edge counting the accept edge itself. The result is held in
// DONE until out_ready.
// Optional build macro AES_CIPHER_KEY_LATCH_EN: capture the whole expanded
// key on accept so that w may change while a block is in flight. Without it,
// w must stay stable from accept until out_valid.
//
// state | meaning
// IDLE  | waiting for a plaintext, in_ready = 1
// RUN   | applying round round_q (1..10), one round per clock
// DONE  | ciphertext on out, out_valid = 1 until out_ready
module aes_cipher_iter (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in,
  input  logic [1407:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Forward S-box. Byte 0 sits in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t          fsm_q, fsm_d;
  logic [3:0]    round_q;
  logic [127:0]  st_q;
  logic          accept;
  logic          last_round;
  logic [1407:0] key_src;
  logic [127:0]  rk;
  logic [7:0]    sb [16];
  logic [7:0]    sr [16];
  logic [7:0]    mc [16];
  logic [127:0]  round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round-key bytes are big-endian within each 32-bit word, so row k of
  // column c pairs with slice byte 4c+(3-k).
  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) begin
        r[8*(4*c+b) +: 8] = s[8*(4*c+b) +: 8] ^ k[8*(4*c+3-b) +: 8];
      end
    end
    return r;
  endfunction

`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [1407:0] key_q;

  // Capture the expanded key with the plaintext; rounds read only this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= w;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = w;
`endif

  // State register of the control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = RUN;
        end
      end
      RUN: begin
        if (last_round) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign last_round = (round_q == 4'd10);

  // Cipher state and round counter; the counter parks at 10 once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            st_q    <= add_round_key(in, w[127:0]);
            round_q <= 4'd1;
          end
        end
        RUN: begin
          st_q <= round_out;
          if (!last_round) begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            round_q <= '0;
          end
        end
        default: round_q <= '0;
      endcase
    end
  end

  // Round-key select by round number.
  always_comb begin
    rk = '0;
    for (int r = 0; r <= 10; r++) begin
      if (round_q == r[3:0]) begin
        rk = key_src[128*r +: 128];
      end
    end
  end

  // SubBytes: sixteen parallel S-box lookups.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      sb[j] = sbox(st_q[8*j +: 8]);
    end
  end

  // ShiftRows: row r of column c comes from column (c+r) mod 4.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  // MixColumns on each column, byte 4c+0 being row 0.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  // AddRoundKey; the final round bypasses MixColumns.
  always_comb begin
    round_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        round_out[8*(4*c+k) +: 8] = (last_round ? sr[4*c+k] : mc[4*c+k])
                                  ^ rk[8*(4*c+3-k) +: 8];
      end
    end
  end

  assign out = st_q;

endmodule
